// File: rtl/tpu_ctrl_pkg.sv
// Shared definitions for the TPU GEMV control path: FSM state encoding,
// SRAM read latency and the nominal per-pass cycle count.
package tpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int SRAM_RD_LAT = 1;

    // Cycles from an accepted start to the end of one pass's write beat.
    function automatic int pass_cycles(input int k, input int as);
        return k + as + 2;
    endfunction

endpackage

// File: rtl/tpu_perf_counter.sv
// Saturating 32-bit busy-cycle counter with a synchronous clear.
module tpu_perf_counter (
    input  logic        clk,
    input  logic        srst,
    input  logic        clr,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    // Clear wins over increment; the count sticks at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tpu_gemv_sequencer.sv
// GEMV pass sequencer for the 8x8 systolic TPU: per pass it streams
// K_ACCUM_DEPTH weight/vector reads, waits for the array to drain, then
// writes one result row. All outputs are registered.
// Optional macro TPU_PERF_CNT_EN adds the perf_cycles busy-cycle counter.
module tpu_gemv_sequencer
    import tpu_ctrl_pkg::*;
#(
    parameter int ARRAY_SIZE    = 8,
    parameter int K_ACCUM_DEPTH = 32,
    parameter int DATA_SET      = 1,
    parameter int W_ADDR_WIDTH  = 6,
    parameter int V_ADDR_WIDTH  = 5,
    parameter int C_ADDR_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    tpu_start,
    output logic [W_ADDR_WIDTH-1:0] sram_raddr_w,
    output logic [V_ADDR_WIDTH-1:0] sram_raddr_v,
    output logic                    array_in_valid,
    output logic                    array_acc_clr,
    output logic                    sram_write_enable_c,
    output logic [C_ADDR_WIDTH-1:0] sram_waddr_c,
    output logic                    busy,
    output logic                    tpu_done
`ifdef TPU_PERF_CNT_EN
    ,
    output logic [31:0]             perf_cycles
`endif
);

    // Drain covers the SRAM read latency plus the array skew.
    localparam int DRAIN_LEN = ARRAY_SIZE + SRAM_RD_LAT;
    localparam int D_W       = $clog2(DRAIN_LEN) + 1;

    localparam logic [V_ADDR_WIDTH-1:0] K_LAST   = V_ADDR_WIDTH'(K_ACCUM_DEPTH - 1);
    localparam logic [C_ADDR_WIDTH-1:0] SET_LAST = C_ADDR_WIDTH'(DATA_SET - 1);
    localparam logic [D_W-1:0]          D_LAST   = D_W'(DRAIN_LEN - 1);
    localparam logic [W_ADDR_WIDTH-1:0] K_W      = W_ADDR_WIDTH'(K_ACCUM_DEPTH);

    if ((K_ACCUM_DEPTH < 1) || (DATA_SET < 1) || (ARRAY_SIZE < 1) ||
        (DATA_SET * K_ACCUM_DEPTH > 2 ** W_ADDR_WIDTH) ||
        (K_ACCUM_DEPTH > 2 ** V_ADDR_WIDTH) ||
        (DATA_SET > 2 ** C_ADDR_WIDTH) ||
        (pass_cycles(K_ACCUM_DEPTH, ARRAY_SIZE) != K_ACCUM_DEPTH + DRAIN_LEN + 1)) begin : g_param_err
        $error("tpu_gemv_sequencer: parameter constraint violated");
    end

    state_e                    state_q, state_d;
    logic [V_ADDR_WIDTH-1:0]   k_q, k_d;
    logic [C_ADDR_WIDTH-1:0]   set_q, set_d;
    logic [D_W-1:0]            drain_q, drain_d;
    logic [W_ADDR_WIDTH-1:0]   raddr_w_q, raddr_w_d;
    logic [V_ADDR_WIDTH-1:0]   raddr_v_q, raddr_v_d;
    logic                      in_valid_q, in_valid_d;
    logic                      acc_clr_q, acc_clr_d;
    logic                      wen_q, wen_d;
    logic [C_ADDR_WIDTH-1:0]   waddr_c_q, waddr_c_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    // Next state and counters; outputs are derived from the next state so
    // that the address for beat k is on the pins in the cycle FETCH k runs.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        set_d   = set_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (tpu_start) begin
                    state_d = ST_FETCH;
                    k_d     = '0;
                    set_d   = '0;
                end
            end
            ST_FETCH: begin
                if (k_q == K_LAST) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == D_LAST) begin
                    state_d = ST_WRITE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_WRITE: begin
                if (set_q != SET_LAST) begin
                    state_d = ST_FETCH;
                    set_d   = set_q + 1'b1;
                    k_d     = '0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        raddr_w_d  = (state_d == ST_FETCH) ? (W_ADDR_WIDTH'(set_d) * K_W) + W_ADDR_WIDTH'(k_d)
                                           : raddr_w_q;
        raddr_v_d  = (state_d == ST_FETCH) ? k_d : raddr_v_q;
        // Read data arrives one cycle after the address, so valid/clear lag FETCH.
        in_valid_d = (state_q == ST_FETCH);
        acc_clr_d  = (state_q == ST_FETCH) && (k_q == '0);
        wen_d      = (state_d != ST_WRITE);
        waddr_c_d  = (state_d == ST_WRITE) ? set_d : waddr_c_q;
        busy_d     = (state_d == ST_FETCH) || (state_d == ST_DRAIN) || (state_d == ST_WRITE);
        done_d     = (state_d == ST_DONE);
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            set_q      <= '0;
            drain_q    <= '0;
            raddr_w_q  <= '0;
            raddr_v_q  <= '0;
            in_valid_q <= 1'b0;
            acc_clr_q  <= 1'b0;
            wen_q      <= 1'b1;
            waddr_c_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            set_q      <= set_d;
            drain_q    <= drain_d;
            raddr_w_q  <= raddr_w_d;
            raddr_v_q  <= raddr_v_d;
            in_valid_q <= in_valid_d;
            acc_clr_q  <= acc_clr_d;
            wen_q      <= wen_d;
            waddr_c_q  <= waddr_c_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign sram_raddr_w        = raddr_w_q;
    assign sram_raddr_v        = raddr_v_q;
    assign array_in_valid      = in_valid_q;
    assign array_acc_clr       = acc_clr_q;
    assign sram_write_enable_c = wen_q;
    assign sram_waddr_c        = waddr_c_q;
    assign busy                = busy_q;
    assign tpu_done            = done_q;

`ifdef TPU_PERF_CNT_EN
    logic start_accept;
    assign start_accept = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && tpu_start;

    tpu_perf_counter u_perf (
        .clk   (clk),
        .srst  (srst),
        .clr   (start_accept),
        .inc   (busy_q),
        .count (perf_cycles)
    );
`endif

endmodule

// File: tb/tb_tpu_gemv_sequencer.sv
// Scoreboard bench for tpu_gemv_sequencer: two instances (DATA_SET=1 and
// DATA_SET=2). Stimulus pushes expected beats/writes/done events; a negedge
// monitor pops and compares as the DUTs present them.
`timescale 1ns/1ps
module tb_tpu_gemv_sequencer;

    localparam int K    = 32;
    localparam int PASS = 42;

    typedef struct {
        int cyc;
        int aw;
        int av;
        int clr;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic       srst [2];
    logic       start [2];
    logic [5:0] raddr_w [2];
    logic [4:0] raddr_v [2];
    logic       in_valid [2];
    logic       acc_clr [2];
    logic       wen [2];
    logic [3:0] waddr_c [2];
    logic       busy [2];
    logic       done [2];
`ifdef TPU_PERF_CNT_EN
    logic [31:0] perf [2];
`endif

    tpu_gemv_sequencer u_dut0 (
        .clk                 (clk),
        .srst                (srst[0]),
        .tpu_start           (start[0]),
        .sram_raddr_w        (raddr_w[0]),
        .sram_raddr_v        (raddr_v[0]),
        .array_in_valid      (in_valid[0]),
        .array_acc_clr       (acc_clr[0]),
        .sram_write_enable_c (wen[0]),
        .sram_waddr_c        (waddr_c[0]),
        .busy                (busy[0]),
        .tpu_done            (done[0])
`ifdef TPU_PERF_CNT_EN
        ,
        .perf_cycles         (perf[0])
`endif
    );

    tpu_gemv_sequencer #(.DATA_SET(2)) u_dut1 (
        .clk                 (clk),
        .srst                (srst[1]),
        .tpu_start           (start[1]),
        .sram_raddr_w        (raddr_w[1]),
        .sram_raddr_v        (raddr_v[1]),
        .array_in_valid      (in_valid[1]),
        .array_acc_clr       (acc_clr[1]),
        .sram_write_enable_c (wen[1]),
        .sram_waddr_c        (waddr_c[1]),
        .busy                (busy[1]),
        .tpu_done            (done[1])
`ifdef TPU_PERF_CNT_EN
        ,
        .perf_cycles         (perf[1])
`endif
    );

    beat_t bq [2][$];
    int    wq_cyc [2][$];
    int    wq_addr [2][$];
    int    dq [2][$];

    task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, d, act, exp, $time);
        end
    endtask

    // Monitor: compares every valid beat, write strobe and done rise.
    int   prev_w [2];
    int   prev_v [2];
    logic prev_done [2];
    beat_t e;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (acc_clr[d] === 1'b1 && in_valid[d] !== 1'b1)
                check("clr_without_valid", d, 1, 0);
            if (in_valid[d] === 1'b1) begin
                if (bq[d].size() == 0) begin
                    check("unexpected_beat", d, cyc, 0);
                end else begin
                    e = bq[d].pop_front();
                    check("beat_cycle", d, cyc, e.cyc);
                    check("beat_raddr_w", d, prev_w[d], e.aw);
                    check("beat_raddr_v", d, prev_v[d], e.av);
                    check("beat_acc_clr", d, acc_clr[d], e.clr);
                end
            end
            if (wen[d] === 1'b0) begin
                if (wq_cyc[d].size() == 0) begin
                    check("unexpected_write", d, cyc, 0);
                end else begin
                    check("write_cycle", d, cyc, wq_cyc[d].pop_front());
                    check("write_addr", d, waddr_c[d], wq_addr[d].pop_front());
                end
            end
            if (done[d] === 1'b1 && prev_done[d] !== 1'b1) begin
                if (dq[d].size() == 0) check("unexpected_done", d, cyc, 0);
                else                   check("done_cycle", d, cyc, dq[d].pop_front());
            end
            prev_w[d]    = int'(raddr_w[d]);
            prev_v[d]    = int'(raddr_v[d]);
            prev_done[d] = done[d];
        end
    end

    // Expected beats/writes/done for a run started at edge e0; beats stop at
    // beat_limit and writes/done are only expected when the run completes.
    task automatic push_run(input int d, input int e0, input int ds, input int beat_limit, input bit complete);
        beat_t b;
        for (int p = 0; p < ds; p++) begin
            for (int j = 0; j < K; j++) begin
                if (p * K + j < beat_limit) begin
                    b.cyc = e0 + p * PASS + j + 1;
                    b.aw  = p * K + j;
                    b.av  = j;
                    b.clr = (j == 0) ? 1 : 0;
                    bq[d].push_back(b);
                end
            end
            if (complete) begin
                wq_cyc[d].push_back(e0 + p * PASS + PASS - 1);
                wq_addr[d].push_back(p);
            end
        end
        if (complete) dq[d].push_back(e0 + ds * PASS);
    endtask

    task automatic wait_empty(input int d, input int limit);
        int n;
        n = 0;
        while ((bq[d].size() + wq_cyc[d].size() + dq[d].size()) != 0 && n < limit) begin
            @(negedge clk); #1;
            n++;
        end
        check("run_pending", d, bq[d].size() + wq_cyc[d].size() + dq[d].size(), 0);
    endtask

    task automatic check_reset(input int d);
        check("rst_raddr_w", d, raddr_w[d], 0);
        check("rst_raddr_v", d, raddr_v[d], 0);
        check("rst_in_valid", d, in_valid[d], 0);
        check("rst_acc_clr", d, acc_clr[d], 0);
        check("rst_wen", d, wen[d], 1);
        check("rst_waddr_c", d, waddr_c[d], 0);
        check("rst_busy", d, busy[d], 0);
        check("rst_done", d, done[d], 0);
`ifdef TPU_PERF_CNT_EN
        check("rst_perf", d, perf[d], 0);
`endif
    endtask

    initial begin
        int e0;
        int e1;
        srst[0] = 1'b1; srst[1] = 1'b1;
        start[0] = 1'b0; start[1] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_reset(0);
        check_reset(1);
        srst[0] = 1'b0; srst[1] = 1'b0;

        // Single pass on dut0 and two passes on dut1, same start edge.
        @(negedge clk); #1;
        e0 = cyc + 1;
        start[0] = 1'b1; start[1] = 1'b1;
        push_run(0, e0, 1, K, 1'b1);
        push_run(1, e0, 2, 2 * K, 1'b1);
        @(negedge clk); #1;
        start[0] = 1'b0; start[1] = 1'b0;
        wait_empty(0, 200);
        wait_empty(1, 200);
        check("done_level", 0, done[0], 1);
        check("done_level", 1, done[1], 1);
        check("done_busy", 0, busy[0], 0);
        check("done_busy", 1, busy[1], 0);
`ifdef TPU_PERF_CNT_EN
        check("perf_one_pass", 0, perf[0], 42);
        check("perf_two_pass", 1, perf[1], 84);
`endif

        // Start held high: ignored mid-run, restarts the cycle after DONE.
        @(negedge clk); #1;
        e0 = cyc + 1;
        e1 = e0 + PASS + 1;
        start[0] = 1'b1;
        push_run(0, e0, 1, K, 1'b1);
        push_run(0, e1, 1, K, 1'b1);
        while (cyc < e1 && cyc < e0 + 100) begin
            @(negedge clk); #1;
        end
        check("restart_done_low", 0, done[0], 0);
        check("restart_raddr_w", 0, raddr_w[0], 0);
        check("restart_busy", 0, busy[0], 1);
`ifdef TPU_PERF_CNT_EN
        check("perf_restart_clear", 0, perf[0], 0);
`endif
        start[0] = 1'b0;
        wait_empty(0, 200);
`ifdef TPU_PERF_CNT_EN
        check("perf_after_restart", 0, perf[0], 42);
`endif

        // Reset during FETCH k=10 aborts without a write.
        @(negedge clk); #1;
        e0 = cyc + 1;
        start[0] = 1'b1;
        push_run(0, e0, 1, 10, 1'b0);
        @(negedge clk); #1;
        start[0] = 1'b0;
        while (cyc < e0 + 10) begin
            @(negedge clk); #1;
        end
        srst[0] = 1'b1;
        @(negedge clk); #1;
        check_reset(0);
        check("abort_beats_left", 0, bq[0].size(), 0);
        srst[0] = 1'b0;

        // Clean pass after the abort.
        @(negedge clk); #1;
        e0 = cyc + 1;
        start[0] = 1'b1;
        push_run(0, e0, 1, K, 1'b1);
        @(negedge clk); #1;
        start[0] = 1'b0;
        wait_empty(0, 200);
        check("post_abort_done", 0, done[0], 1);
        repeat (3) @(negedge clk);
        #1;
        check("final_wq", 0, wq_cyc[0].size() + wq_cyc[1].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
